paicore_xfer_ctrl: RTL and testbench
====================================

PAICORE_XFER_CTRL -- requirements
Module: paicore_xfer_ctrl

Interface
REQ-001 Parameter DP_RST_CYCLES, default 4: number of cycles dp_rst is held high per datapath reset.
REQ-002 Parameter TMO_W, default 32: width of the timeout and cycle counters.
REQ-003 Clock and reset are clk (input, 1) and rst (input, 1); rst is synchronous and active-high.
REQ-004 Port start, input, 1: a one-cycle request to begin a transfer.
REQ-005 Port abort, input, 1: cancels the current transfer.
REQ-006 Port cfg_send_len, input, 32: number of frames to transmit.
REQ-007 Port cfg_frame_num, input, 32: maximum number of output frames expected.
REQ-008 Port cfg_timeout, input, TMO_W: timeout limit in cycles; 0 disables the timeout.
REQ-009 Port dp_rst, output, 1: active-high reset to the send/recv datapath.
REQ-010 Port send_len, output, 32: latched cfg_send_len, driven to the datapath.
REQ-011 Port oFrameNumMax, output, 32: latched cfg_frame_num, driven to the datapath.
REQ-012 Port rx_rcving, output, 1: receive-enable to the datapath.
REQ-013 Port tx_done, input, 1, and port rx_done, input, 1: datapath completion strobes.
REQ-014 Output ports busy (1), done (1, pulse), err_timeout (1), err_abort (1) and cycles (TMO_W) report status.

Function
REQ-015 States are IDLE, DPRST, TX, RX, FIN and ERR; the state is encoded in a 3-bit register.
REQ-016 IDLE: on start, latch cfg_send_len, cfg_frame_num and cfg_timeout, clear both err flags, clear cycles, and go to DPRST.
REQ-017 A start received outside IDLE is ignored.
REQ-018 DPRST: hold dp_rst high for exactly DP_RST_CYCLES cycles; the next state is TX, or FIN when the latched send_len is 0.
REQ-019 TX: rx_rcving is 1; on tx_done, go to RX.
REQ-020 A rx_done seen in TX (before or together with tx_done) is latched in a sticky rx_seen flag.
REQ-021 RX: rx_rcving is 1; on rx_done or rx_seen, go to FIN.
REQ-022 FIN: done is high for exactly 1 cycle, then the block goes to IDLE.
REQ-023 busy is 1 in every state except IDLE.
REQ-024 cycles increments each cycle in TX and RX and saturates at all-ones; it holds its value in IDLE.
REQ-025 Timeout: when the latched timeout is non-zero and cycles equals it while in TX or RX, set err_timeout and go to ERR.
REQ-026 Abort: in DPRST, TX or RX, abort sets err_abort and goes to ERR.
REQ-027 Abort in IDLE or FIN has no effect; abort takes priority over timeout, which takes priority over completion.
REQ-028 ERR: hold dp_rst high for DP_RST_CYCLES cycles, then go to IDLE without pulsing done.
REQ-029 err_timeout and err_abort are sticky until the next accepted start.
REQ-030 tx_done and rx_done are ignored in IDLE, DPRST, FIN and ERR.
REQ-031 The rx_seen flag clears on entry to DPRST.

Reset
REQ-032 On rst, the state is IDLE; busy, done, rx_rcving and both err flags are 0; cycles, send_len and oFrameNumMax are 0; rx_seen is 0.
REQ-033 On rst, dp_rst is 1 for one cycle, so the datapath is reset together with the controller.
REQ-034 An rst in the middle of a transfer abandons it with no done pulse.

Structure
REQ-035 The state encoding, DP_RST_CYCLES default and TMO_W default belong in the shared package paicore_ctrl_pkg.
REQ-036 One sub-module, paicore_pulse_stretch, generates the DP_RST_CYCLES-wide dp_rst pulse for both DPRST and ERR.
REQ-037 The block contains no other sub-modules.

Verification
REQ-038 Normal transfer: send_len=8, frame_num=8, timeout=0, start; tx_done at cycle 20, rx_done at cycle 30 -> dp_rst high for 4 cycles, done pulses once, err flags stay 0, cycles is about 25.
REQ-039 Early receive: rx_done arrives 3 cycles before tx_done, and in a second run in the same cycle -> FIN is entered 1 cycle after tx_done in both runs.
REQ-040 Timeout: timeout=50 with no tx_done -> err_timeout=1 when cycles=50, dp_rst high for 4 cycles, busy falls, done never pulses.
REQ-041 Abort in RX, and abort with timeout in the same cycle -> err_abort=1 and err_timeout=0 in both cases, then return to IDLE.
REQ-042 send_len=0 -> DPRST then FIN, with rx_rcving never high; a start while busy is ignored.
REQ-043 rst asserted in TX -> all outputs take their reset values on the next cycle and dp_rst pulses for 1 cycle.

Source files
------------

// File: rtl/paicore_ctrl_pkg.sv
// Shared definitions for the PAICORE transfer controller: state encoding and
// parameter defaults.
package paicore_ctrl_pkg;

    localparam int unsigned DpRstCyclesDef = 4;
    localparam int unsigned TmoWDef        = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDprst = 3'd1,
        StTx    = 3'd2,
        StRx    = 3'd3,
        StFin   = 3'd4,
        StErr   = 3'd5
    } xfer_state_e;

endpackage

// File: rtl/paicore_pulse_stretch.sv
// Registered pulse stretcher: a trigger produces a Cycles-wide high pulse that
// starts on the same edge; rst itself yields a single-cycle pulse.
module paicore_pulse_stretch
    import paicore_ctrl_pkg::*;
#(
    parameter int unsigned Cycles = DpRstCyclesDef
) (
    input  logic clk,
    input  logic rst,
    input  logic i_trig,
    output logic o_pulse,
    output logic o_last
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] r_cnt;
    logic            r_pulse;

    // r_cnt holds the number of pulse cycles still to come after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
        end else if (i_trig) begin
            r_cnt   <= CntW'(Cycles - 1);
            r_pulse <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - CntW'(1);
            r_pulse <= 1'b1;
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;
    assign o_last  = (r_cnt == '0);

endmodule

// File: rtl/paicore_xfer_ctrl.sv
// Transfer controller: resets the send/recv datapath, sequences TX then RX,
// and reports completion, timeout and abort status.
module paicore_xfer_ctrl
    import paicore_ctrl_pkg::*;
#(
    parameter int unsigned DP_RST_CYCLES = DpRstCyclesDef,
    parameter int unsigned TMO_W         = TmoWDef
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_send_len,
    input  logic [31:0]      cfg_frame_num,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             dp_rst,
    output logic [31:0]      send_len,
    output logic [31:0]      oFrameNumMax,
    output logic             rx_rcving,
    input  logic             tx_done,
    input  logic             rx_done,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_abort,
    output logic [TMO_W-1:0] cycles
);

    xfer_state_e      r_state;
    xfer_state_e      w_state_nxt;
    logic [31:0]      r_send_len;
    logic [31:0]      r_frame_num;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_cycles;
    logic             r_err_tmo;
    logic             r_err_abort;
    logic             r_rx_seen;

    logic w_tmo_hit;
    logic w_active;
    logic w_accept;
    logic w_trig;
    logic w_last;

    assign w_tmo_hit = (r_tmo != '0) && (r_cycles == r_tmo);
    assign w_active  = (r_state == StTx) || (r_state == StRx);
    assign w_accept  = (r_state == StIdle) && start;

    // Priority in every working state: abort, then timeout, then completion.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StDprst;
            StDprst: begin
                if (abort)       w_state_nxt = StErr;
                else if (w_last) w_state_nxt = (r_send_len == '0) ? StFin : StTx;
            end
            StTx: begin
                if (abort)          w_state_nxt = StErr;
                else if (w_tmo_hit) w_state_nxt = StErr;
                else if (tx_done)   w_state_nxt = StRx;
            end
            StRx: begin
                if (abort)                       w_state_nxt = StErr;
                else if (w_tmo_hit)              w_state_nxt = StErr;
                else if (rx_done || r_rx_seen)   w_state_nxt = StFin;
            end
            StFin:   w_state_nxt = StIdle;
            StErr:   if (w_last) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Fire on entry so the pulse lines up with the first DPRST/ERR cycle.
    assign w_trig = (w_state_nxt != r_state) &&
                    ((w_state_nxt == StDprst) || (w_state_nxt == StErr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_send_len  <= '0;
            r_frame_num <= '0;
            r_tmo       <= '0;
            r_cycles    <= '0;
            r_err_tmo   <= 1'b0;
            r_err_abort <= 1'b0;
            r_rx_seen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_send_len  <= cfg_send_len;
                r_frame_num <= cfg_frame_num;
                r_tmo       <= cfg_timeout;
                r_cycles    <= '0;
                r_err_tmo   <= 1'b0;
                r_err_abort <= 1'b0;
                r_rx_seen   <= 1'b0;
            end else begin
                if (w_active && (r_cycles != '1)) r_cycles <= r_cycles + TMO_W'(1);
                if (abort && (w_active || (r_state == StDprst))) r_err_abort <= 1'b1;
                if (w_active && !abort && w_tmo_hit) r_err_tmo <= 1'b1;
                if ((r_state == StTx) && rx_done) r_rx_seen <= 1'b1;
            end
        end
    end

    paicore_pulse_stretch #(
        .Cycles (DP_RST_CYCLES)
    ) u_dp_rst_stretch (
        .clk     (clk),
        .rst     (rst),
        .i_trig  (w_trig),
        .o_pulse (dp_rst),
        .o_last  (w_last)
    );

    assign send_len     = r_send_len;
    assign oFrameNumMax = r_frame_num;
    assign rx_rcving    = w_active;
    assign busy         = (r_state != StIdle);
    assign done         = (r_state == StFin);
    assign err_timeout  = r_err_tmo;
    assign err_abort    = r_err_abort;
    assign cycles       = r_cycles;

endmodule

// File: tb/tb_paicore_xfer_ctrl.sv
// Directed bench for paicore_xfer_ctrl: normal, early-receive, timeout, abort,
// zero-length and mid-transfer reset scenarios.
module tb_paicore_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [31:0] cfg_send_len = '0;
    logic [31:0] cfg_frame_num = '0;
    logic [31:0] cfg_timeout = '0;
    logic        dp_rst;
    logic [31:0] send_len;
    logic [31:0] oFrameNumMax;
    logic        rx_rcving;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_abort;
    logic [31:0] cycles;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_dp = 0;
    int n_rx = 0;
    int b_done, b_dp, b_rx;

    paicore_xfer_ctrl #(
        .DP_RST_CYCLES (4),
        .TMO_W         (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_send_len  (cfg_send_len),
        .cfg_frame_num (cfg_frame_num),
        .cfg_timeout   (cfg_timeout),
        .dp_rst        (dp_rst),
        .send_len      (send_len),
        .oFrameNumMax  (oFrameNumMax),
        .rx_rcving     (rx_rcving),
        .tx_done       (tx_done),
        .rx_done       (rx_done),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .err_abort     (err_abort),
        .cycles        (cycles)
    );

    always #5 clk = ~clk;

    // Pulse-width counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done)      n_done <= n_done + 1;
        if (dp_rst)    n_dp   <= n_dp + 1;
        if (rx_rcving) n_rx   <= n_rx + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        b_done = n_done;
        b_dp   = n_dp;
        b_rx   = n_rx;
    endtask

    // Start a transfer and step through the 4-cycle DPRST into the first TX cycle.
    task automatic run_to_tx(input logic [31:0] sl, input logic [31:0] fn,
                             input logic [31:0] tmo);
        cfg_send_len  = sl;
        cfg_frame_num = fn;
        cfg_timeout   = tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        // Reset
        tick();
        chk("rst_dp_rst", dp_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_rcving", rx_rcving, 0);
        chk("rst_errs", {err_timeout, err_abort}, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_lens", send_len | oFrameNumMax, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_dp_rst_drop", dp_rst, 0);

        // Normal transfer
        mark();
        run_to_tx(8, 8, 0);
        chk("norm_dp_width", n_dp - b_dp, 4);
        chk("norm_in_tx", rx_rcving, 1);
        chk("norm_cycles0", cycles, 0);
        repeat (15) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("norm_rx_cycles", cycles, 16);
        chk("norm_rx_done_low", done, 0);
        repeat (10) tick();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("norm_fin_done", done, 1);
        chk("norm_fin_cycles", cycles, 27);
        tick();
        chk("norm_idle_busy", busy, 0);
        tick();
        chk("norm_done_count", n_done - b_done, 1);
        chk("norm_errs", {err_timeout, err_abort}, 0);
        chk("norm_cycles_hold", cycles, 27);
        chk("norm_send_len", send_len, 8);
        chk("norm_frame_num", oFrameNumMax, 8);

        // Early receive, rx_done three cycles ahead of tx_done
        run_to_tx(5, 3, 0);
        chk("early_send_len", send_len, 5);
        chk("early_frame_num", oFrameNumMax, 3);
        tick();
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("early_a_rx", rx_rcving, 1);
        tick();
        chk("early_a_fin", done, 1);
        tick();
        chk("early_a_idle", busy, 0);

        // Early receive, rx_done together with tx_done
        run_to_tx(5, 3, 0);
        tick();
        tx_done = 1'b1;
        rx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        rx_done = 1'b0;
        chk("early_b_no_done", done, 0);
        tick();
        chk("early_b_fin", done, 1);
        tick();

        // Timeout at 50 with no tx_done
        mark();
        run_to_tx(8, 8, 50);
        repeat (50) tick();
        chk("tmo_cycles", cycles, 50);
        chk("tmo_not_yet", err_timeout, 0);
        mark();
        tick();
        chk("tmo_flag", err_timeout, 1);
        chk("tmo_abort_flag", err_abort, 0);
        chk("tmo_rx_off", rx_rcving, 0);
        repeat (3) tick();
        chk("tmo_err_busy", busy, 1);
        tick();
        chk("tmo_idle", busy, 0);
        chk("tmo_dp_width", n_dp - b_dp, 4);
        tick();
        chk("tmo_no_done", n_done - b_done, 0);
        chk("tmo_sticky", err_timeout, 1);

        // Abort in RX; also shows rx_seen was cleared by the new DPRST
        mark();
        cfg_send_len = 8;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_tmo_cleared", err_timeout, 0);
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("abort_still_rx", rx_rcving, 1);
        chk("abort_no_stale_fin", done, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_rx_flag", err_abort, 1);
        chk("abort_rx_tmo_flag", err_timeout, 0);
        repeat (4) tick();
        chk("abort_rx_idle", busy, 0);
        tick();
        chk("abort_rx_no_done", n_done - b_done, 0);

        // Abort and timeout in the same cycle
        run_to_tx(8, 8, 3);
        repeat (3) tick();
        chk("both_cycles", cycles, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("both_abort_flag", err_abort, 1);
        chk("both_tmo_flag", err_timeout, 0);
        repeat (4) tick();
        chk("both_idle", busy, 0);

        // Zero-length transfer, start while busy, abort in FIN and IDLE
        mark();
        cfg_send_len = 0;
        cfg_timeout  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cfg_send_len = 9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("zero_fin", done, 1);
        abort = 1'b1;
        tick();
        chk("zero_idle", busy, 0);
        tick();
        abort = 1'b0;
        chk("zero_abort_ignored", err_abort, 0);
        chk("zero_send_len", send_len, 0);
        chk("zero_dp_width", n_dp - b_dp, 4);
        chk("zero_rx_never", n_rx - b_rx, 0);
        chk("zero_done_count", n_done - b_done, 1);

        // Reset in the middle of TX
        mark();
        run_to_tx(8, 6, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_rx_rcving", rx_rcving, 0);
        chk("mrst_cycles", cycles, 0);
        chk("mrst_frame_num", oFrameNumMax, 0);
        chk("mrst_dp_rst", dp_rst, 1);
        tick();
        chk("mrst_dp_rst_drop", dp_rst, 0);
        tick();
        chk("mrst_no_done", n_done - b_done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
